// File: rtl/bist_pkg.sv
// Shared types, widths and helpers for the BIST pattern controller.
// Contents: FSM state enum, LFSR/MISR/response widths, counter widths,
// LFSR and MISR feedback tap masks, and the LFSR step function.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int unsigned LFSR_W = 12;
   localparam int unsigned MISR_W = 16;
   localparam int unsigned RESP_W = 8;
   localparam int unsigned CNT_W  = 12;
   localparam int unsigned WAIT_W = 4;

   // x^12 + x^6 + x^4 + x + 1 -> feedback from bits 11, 5, 3, 0
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 12'h829;
   // MISR feedback from bits 15, 13, 12, 10
   localparam logic [MISR_W-1:0] MISR_TAPS = 16'hB400;

   // One LFSR step: shift left, feedback XOR of tapped bits into bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/bist_pattern_ctrl_if.sv
// Pattern/response and status bundle between the BIST controller and its user.
// Signals:
//   start     - begin a run (user -> controller)
//   dut_in    - 12-bit stimulus vector to the netlist (controller -> user)
//   dut_out   - 8-bit netlist response (user -> controller)
//   busy      - run in progress
//   done      - run finished, signature final
//   signature - 16-bit MISR value
//   pass      - done and signature matches the golden value
interface bist_pattern_ctrl_if;
   import bist_pkg::*;

   logic              start;
   logic [LFSR_W-1:0] dut_in;
   logic [RESP_W-1:0] dut_out;
   logic              busy;
   logic              done;
   logic [MISR_W-1:0] signature;
   logic              pass;

   modport master (
      input  start, dut_out,
      output dut_in, busy, done, signature, pass
   );

   modport slave (
      output start, dut_out,
      input  dut_in, busy, done, signature, pass
   );

endinterface

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register compacting 8-bit responses.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   clr      - synchronous clear to zero (start of a run)
//   en       - fold d into the signature this cycle
//   d        - 8-bit response
//   sig      - current signature
module bist_misr
   import bist_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [RESP_W-1:0] d,
   output logic [MISR_W-1:0] sig
);

   // Shift with tapped feedback, then XOR the response into the low byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= {sig[MISR_W-2:0], ^(sig & MISR_TAPS)} ^ MISR_W'(d);
      end
   end

endmodule

// File: rtl/bist_pattern_ctrl.sv
// BIST stimulus/response controller for 12-in/8-out combinational netlists.
// Applies LFSR vectors, waits SETTLE_CYCLES, compacts responses into a MISR,
// and reports done/pass after N_PATTERNS vectors.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - master side of bist_pattern_ctrl_if (start, dut_in, dut_out,
//              busy, done, signature, pass)
module bist_pattern_ctrl
   import bist_pkg::*;
#(
   parameter int unsigned       N_PATTERNS    = 256,
   parameter int unsigned       SETTLE_CYCLES = 0,
   parameter logic [LFSR_W-1:0] SEED          = 12'hACE,
   parameter logic [MISR_W-1:0] GOLDEN        = 16'h0000
) (
   input  logic                 clk,
   input  logic                 rst,
   bist_pattern_ctrl_if.master  bus
);

   // An all-zero LFSR would lock up, so a zero seed becomes 1.
   localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == '0) ? LFSR_W'(1) : SEED;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_PATTERNS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE_CYCLES - 1);
   localparam bit                HAS_SETTLE = (SETTLE_CYCLES > 0);

   state_t            state;
   state_t            state_nxt;
   logic [LFSR_W-1:0] lfsr;
   logic [CNT_W-1:0]  cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [MISR_W-1:0] sig;
   logic              load_c;
   logic              capture_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_nxt = HAS_SETTLE ? SETTLE : CAPTURE;
            end
         end
         SETTLE: begin
            if (wait_cnt == WAIT_LAST) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            if (cnt == CNT_LAST) begin
               state_nxt = DONE;
            end else if (HAS_SETTLE) begin
               state_nxt = SETTLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output and datapath-control decode from state
   always_comb begin
      load_c    = 1'b0;
      capture_c = 1'b0;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      bus.pass  = 1'b0;
      case (state)
         IDLE: begin
            load_c = bus.start;
         end
         SETTLE: begin
            bus.busy = 1'b1;
         end
         CAPTURE: begin
            bus.busy  = 1'b1;
            capture_c = 1'b1;
         end
         DONE: begin
            bus.done = 1'b1;
            bus.pass = (sig == GOLDEN);
            load_c   = bus.start;
         end
         default: ;
      endcase
   end

   // Pattern generator and counters; the vector holds outside CAPTURE.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr     <= SEED_EFF;
         cnt      <= '0;
         wait_cnt <= '0;
      end else if (load_c) begin
         lfsr     <= SEED_EFF;
         cnt      <= '0;
         wait_cnt <= '0;
      end else if (capture_c) begin
         lfsr     <= lfsr_next(lfsr);
         cnt      <= cnt + CNT_W'(1);
         wait_cnt <= '0;
      end else if (state == SETTLE) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   bist_misr u_misr (
      .clk (clk),
      .rst (rst),
      .clr (load_c),
      .en  (capture_c),
      .d   (bus.dut_out),
      .sig (sig)
   );

   assign bus.dut_in    = lfsr;
   assign bus.signature = sig;

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Self-checking bench for bist_pattern_ctrl: five differently parameterised
// instances driven in loopback (dut_out = dut_in[7:0]) with noise injected
// on every non-capture cycle, checked each cycle against a pattern-level model.
module tb_bist_pattern_ctrl;

   localparam int NI = 5;

   function automatic int unsigned cfg_n(input int g);
      case (g)
         0: return 1;
         1: return 2;
         2: return 2;
         3: return 4;
         default: return 4095;
      endcase
   endfunction

   function automatic int unsigned cfg_s(input int g);
      return (g == 3) ? 3 : 0;
   endfunction

   function automatic logic [11:0] cfg_seed(input int g);
      return (g == 4) ? 12'h000 : 12'hACE;
   endfunction

   function automatic logic [15:0] cfg_golden(input int g);
      return (g == 1) ? 16'h0100 : 16'h0000;
   endfunction

   // Reference LFSR / MISR steps written from the polynomial definitions.
   function automatic logic [11:0] ref_lfsr(input logic [11:0] v);
      logic fb;
      fb = v[11] ^ v[5] ^ v[3] ^ v[0];
      return {v[10:0], fb};
   endfunction

   function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [7:0] r);
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      return {s[14:0], fb} ^ {8'h00, r};
   endfunction

   logic clk = 1'b0;
   logic rst;
   logic        start_a   [NI];
   logic [7:0]  mask      [NI];
   logic [11:0] dut_in_a  [NI];
   logic        busy_a    [NI];
   logic        done_a    [NI];
   logic [15:0] sig_a     [NI];
   logic        pass_a    [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : gi
      bist_pattern_ctrl_if bus ();
      bist_pattern_ctrl #(
         .N_PATTERNS    (cfg_n(g)),
         .SETTLE_CYCLES (cfg_s(g)),
         .SEED          (cfg_seed(g)),
         .GOLDEN        (cfg_golden(g))
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
      assign bus.start   = start_a[g];
      assign bus.dut_out = bus.dut_in[7:0] ^ mask[g];
      assign dut_in_a[g] = bus.dut_in;
      assign busy_a[g]   = bus.busy;
      assign done_a[g]   = bus.done;
      assign sig_a[g]    = bus.signature;
      assign pass_a[g]   = bus.pass;
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d] at %0t: got %h expected %h", name, g, $time, act, exp);
      end
   endtask

   // Model: phase 0 idle, 1 running, 2 done; c = cycle within the current vector.
   int          m_phase [NI];
   int          m_c     [NI];
   int          m_j     [NI];
   logic [11:0] m_vec   [NI];
   logic [15:0] m_sig   [NI];

   function automatic logic [11:0] seed_eff(input int g);
      return (cfg_seed(g) == 12'h000) ? 12'h001 : cfg_seed(g);
   endfunction

   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (rst) begin
            m_phase[g] = 0;
            m_vec[g]   = seed_eff(g);
            m_sig[g]   = '0;
            m_c[g]     = 0;
            m_j[g]     = 0;
         end else if (m_phase[g] == 1) begin
            if (m_c[g] == int'(cfg_s(g))) begin
               m_sig[g] = ref_misr(m_sig[g], m_vec[g][7:0]);
               m_vec[g] = ref_lfsr(m_vec[g]);
               m_j[g]++;
               m_c[g] = 0;
               if (m_j[g] == int'(cfg_n(g))) m_phase[g] = 2;
            end else begin
               m_c[g]++;
            end
         end else if (start_a[g]) begin
            m_phase[g] = 1;
            m_vec[g]   = seed_eff(g);
            m_sig[g]   = '0;
            m_c[g]     = 0;
            m_j[g]     = 0;
         end
      end
   end

   bit track4 = 1'b0;
   bit seen [4096];
   int seen_cnt = 0;
   int dup_cnt  = 0;
   int zero_cnt = 0;

   // Per-cycle compare against the model, then pick the dut_out noise for the next edge.
   initial begin
      for (int g = 0; g < NI; g++) mask[g] = 8'h00;
      forever begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            logic exp_done;
            exp_done = (m_phase[g] == 2);
            chk("dut_in",    g, 32'(dut_in_a[g]), 32'(m_vec[g]));
            chk("busy",      g, 32'(busy_a[g]),   32'(m_phase[g] == 1));
            chk("done",      g, 32'(done_a[g]),   32'(exp_done));
            chk("signature", g, 32'(sig_a[g]),    32'(m_sig[g]));
            chk("pass",      g, 32'(pass_a[g]),   32'(exp_done && (m_sig[g] == cfg_golden(g))));
            if (m_phase[g] == 1 && m_c[g] == int'(cfg_s(g)))
               mask[g] = 8'h00;
            else
               mask[g] = 8'($urandom_range(1, 255));
         end
         if (track4 && m_phase[4] == 1) begin
            if (dut_in_a[4] == 12'h000) zero_cnt++;
            else if (seen[dut_in_a[4]]) dup_cnt++;
            seen[dut_in_a[4]] = 1'b1;
            seen_cnt++;
         end
      end
   end

   task automatic wait_done(input int g, input int budget, output int cycles);
      cycles = 0;
      while (!done_a[g] && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      if (!done_a[g]) begin
         tests++;
         fails++;
         $display("FAIL timeout[%0d]: done not seen within %0d cycles", g, budget);
      end
   endtask

   initial begin
      int busy_cnt;
      int done_at;
      int n;
      logic [15:0] exp3;
      logic [15:0] exp4;

      rst = 1'b1;
      for (int g = 0; g < NI; g++) start_a[g] = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values
      for (int g = 0; g < NI; g++) begin
         chk("rst_dut_in", g, 32'(dut_in_a[g]), (g == 4) ? 32'h001 : 32'hACE);
         chk("rst_busy",   g, 32'(busy_a[g]), 32'd0);
         chk("rst_done",   g, 32'(done_a[g]), 32'd0);
         chk("rst_sig",    g, 32'(sig_a[g]),  32'd0);
         chk("rst_pass",   g, 32'(pass_a[g]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Short loopback runs plus the settle run, with a start pulse mid-run on inst 3
      for (int g = 0; g < 4; g++) start_a[g] = 1'b1;
      busy_cnt = 0;
      done_at  = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (cyc == 1) for (int g = 0; g < 4; g++) start_a[g] = 1'b0;
         if (cyc == 6) start_a[3] = 1'b1;
         if (cyc == 7) start_a[3] = 1'b0;
         if (cyc == 1) begin
            chk("n1_done_early", 0, 32'(done_a[0]), 32'd0);
            chk("n2_vec0",       1, 32'(dut_in_a[1]), 32'hACE);
         end
         if (cyc == 2) begin
            chk("n1_done",  0, 32'(done_a[0]), 32'd1);
            chk("n1_sig",   0, 32'(sig_a[0]), 32'h00CE);
            chk("n2_vec1",  1, 32'(dut_in_a[1]), 32'h59C);
         end
         if (cyc == 3) begin
            chk("n2_sig",     1, 32'(sig_a[1]), 32'h0100);
            chk("n2_pass_g",  1, 32'(pass_a[1]), 32'd1);
            chk("n2_sig_b",   2, 32'(sig_a[2]), 32'h0100);
            chk("n2_pass_0",  2, 32'(pass_a[2]), 32'd0);
         end
         if (busy_a[3]) busy_cnt++;
         if (done_a[3] && done_at == 0) done_at = cyc;
      end
      chk("s3_busy_cycles", 3, 32'(busy_cnt), 32'd16);
      chk("s3_done_cycle",  3, 32'(done_at),  32'd17);
      exp3 = m_sig[3];

      // Reset mid-run, then clean rerun
      start_a[3] = 1'b1;
      @(negedge clk);
      start_a[3] = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy",   3, 32'(busy_a[3]),   32'd0);
      chk("midrst_done",   3, 32'(done_a[3]),   32'd0);
      chk("midrst_sig",    3, 32'(sig_a[3]),    32'd0);
      chk("midrst_dut_in", 3, 32'(dut_in_a[3]), 32'hACE);
      rst = 1'b0;
      @(negedge clk);
      start_a[3] = 1'b1;
      @(negedge clk);
      start_a[3] = 1'b0;
      wait_done(3, 40, n);
      chk("rerun_len", 3, 32'(n),        32'd16);
      chk("rerun_sig", 3, 32'(sig_a[3]), 32'(exp3));

      // Zero seed, 4095 patterns: every vector distinct and nonzero
      track4 = 1'b1;
      @(negedge clk);
      start_a[4] = 1'b1;
      @(negedge clk);
      start_a[4] = 1'b0;
      wait_done(4, 5000, n);
      track4 = 1'b0;
      chk("long_len",   4, 32'(n),        32'd4095);
      chk("long_seen",  4, 32'(seen_cnt), 32'd4095);
      chk("long_dups",  4, 32'(dup_cnt),  32'd0);
      chk("long_zeros", 4, 32'(zero_cnt), 32'd0);
      exp4 = m_sig[4];

      // Restart directly from DONE
      start_a[4] = 1'b1;
      @(negedge clk);
      start_a[4] = 1'b0;
      chk("restart_done", 4, 32'(done_a[4]), 32'd0);
      chk("restart_busy", 4, 32'(busy_a[4]), 32'd1);
      wait_done(4, 5000, n);
      chk("restart_len", 4, 32'(n),        32'd4095);
      chk("restart_sig", 4, 32'(sig_a[4]), 32'(exp4));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bist_pattern_ctrl.md
# bist_pattern_ctrl

Sequential stimulus/response end for the 12-in/8-out mapped combinational netlists. It drives pseudo-random input vectors from a 12-bit LFSR into the netlist, waits a programmable settle time, and compacts each 8-bit response into a 16-bit MISR signature. After N patterns it flags done and compares the signature against a golden value, giving a self-checking wrapper for mapped and rewired netlist variants.

## Interface
- N_PATTERNS, 256: patterns applied per run; legal range 1..4096.
- SETTLE_CYCLES, 0: idle cycles between applying a vector and capturing its response; legal range 0..15.
- SEED, 12'hACE: LFSR load value; a value of 0 is replaced by 12'h001.
- GOLDEN, 16'h0000: expected final signature.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE and DONE.
- dut_in  out  12  vector to netlist inputs; equals the LFSR register.
- dut_out  in  8  netlist response.
- busy  out  1  high in SETTLE and CAPTURE.
- done  out  1  high in DONE.
- signature  out  16  MISR register.
- pass  out  1  done && (signature == GOLDEN).

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE/DONE, start=1: load lfsr<=SEED (0 replaced by 1), sig<=0, cnt<=0, wait<=0; next state SETTLE if SETTLE_CYCLES>0, else CAPTURE. With start=0, stay in the current state.
- SETTLE: hold dut_in; wait++. When wait==SETTLE_CYCLES-1, go to CAPTURE.
- CAPTURE (one cycle):
  - MISR: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {8'h00, dut_out}.
  - LFSR: lfsr <= {lfsr[10:0], lfsr[11]^lfsr[5]^lfsr[3]^lfsr[0]} (maximal length, x^12+x^6+x^4+x+1).
  - cnt++, wait<=0.
  - If cnt==N_PATTERNS-1, go to DONE. Otherwise go to SETTLE, or stay in CAPTURE when SETTLE_CYCLES==0.
- DONE: signature and pass hold until the next start or rst. The LFSR does not advance.
- start during SETTLE/CAPTURE is ignored; the run is not restarted.
- Counter widths: cnt is 12 bits and wait is 4 bits. No wrap is possible inside legal parameter ranges.

## Timing
- Reset values: state=IDLE, dut_in=SEED (0 replaced by 1), busy=0, done=0, signature=16'h0000, pass=0.
- rst has priority over every event, including mid-run. It returns to IDLE on the next edge and discards the partial signature.
- dut_in is registered. A vector is stable for exactly SETTLE_CYCLES+1 cycles, and dut_out is sampled at the end of the last of those cycles.
- Run length: start edge to first done=1 cycle is N_PATTERNS*(SETTLE_CYCLES+1) cycles after the start-sampling edge.
- done and pass are registered/decoded from state. pass is valid in the same cycle done rises.
- A start in DONE begins a new run the next cycle: done falls and busy rises on that same edge.

## Structure
- Package bist_pkg holds:
  - state enum (IDLE, SETTLE, CAPTURE, DONE);
  - LFSR_W=12, MISR_W=16, RESP_W=8;
  - LFSR tap mask 12'h829 and MISR tap mask 16'hB400;
  - a function lfsr_next().
- Sub-module bist_misr: 16-bit MISR with ports clk, rst, clr, en, d[7:0], sig[15:0]. Its update equation matches Operation.
- The controller FSM, LFSR and counters live in the top.

## Test plan
- Reset: assert rst 2 cycles -> dut_in=12'hACE, busy=0, done=0, signature=0, pass=0.
- Loopback dut_out=dut_in[7:0], N=1, S=0, start pulse:
  - done rises 1 cycle after the start edge;
  - signature=16'h00CE.
- Same loopback, N=2, S=0:
  - second vector dut_in=12'h59C;
  - final signature=16'h0100;
  - GOLDEN=16'h0100 gives pass=1, GOLDEN=0 gives pass=0.
- S=3, N=4: each dut_in held exactly 4 cycles; busy high for 16 cycles; dut_out toggled mid-settle does not affect the signature.
- start pulsed during busy -> ignored, run length unchanged. rst asserted mid-run -> IDLE next cycle with reset values, then a clean rerun gives the identical signature.
- SEED=0, N=4095, S=0 -> no repeated dut_in value and none equal 0. A restart from DONE reproduces the same signature.
